// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage buffers: FSM encodings, the RISC-V
// NOP bubble, and bit offsets of the packed payloads carried across each
// core stage boundary.
package pipe_pkg;

    // Stage buffer occupancy states. The encoding equals the entry count.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_BUSY  = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b10;

    // addi x0, x0, 0 -- the bubble that IF/ID instances present after a flush.
    localparam logic [31:0] RV_NOP = 32'h00000013;

    // IF/ID payload: {pc, instr}
    localparam int IFID_INSTR_LSB = 0;
    localparam int IFID_PC_LSB    = 32;
    localparam int IFID_W         = 64;

    // ID/EX payload: {ctrl[7:0], rd[4:0], imm[31:0], rs2v[31:0], rs1v[31:0], pc[31:0]}
    localparam int IDEX_PC_LSB    = 0;
    localparam int IDEX_RS1V_LSB  = 32;
    localparam int IDEX_RS2V_LSB  = 64;
    localparam int IDEX_IMM_LSB   = 96;
    localparam int IDEX_RD_LSB    = 128;
    localparam int IDEX_CTRL_LSB  = 133;
    localparam int IDEX_W         = 141;

    // EX/MEM payload: {ctrl[3:0], rd[4:0], store_data[31:0], alu_res[31:0]}
    localparam int EXMEM_ALU_LSB  = 0;
    localparam int EXMEM_STD_LSB  = 32;
    localparam int EXMEM_RD_LSB   = 64;
    localparam int EXMEM_CTRL_LSB = 69;
    localparam int EXMEM_W        = 73;

    // MEM/WB payload: {wb_en, rd[4:0], wb_data[31:0]}
    localparam int MEMWB_DATA_LSB = 0;
    localparam int MEMWB_RD_LSB   = 32;
    localparam int MEMWB_WBEN_LSB = 37;
    localparam int MEMWB_W        = 38;

endpackage

// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, stall and flush.
// SKID=1: two-entry skid buffer with a registered o_ready, so backpressure
// never forms a combinational path across stages.
// SKID=0: single register, o_ready = !o_valid | i_ready.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int               WIDTH      = 32,
    parameter bit               SKID       = 1'b1,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_count
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] w_main_nxt;
    logic             w_ready;
    logic             w_in_fire;
    logic             w_out_fire;

    assign w_in_fire  = i_valid & w_ready;
    assign w_out_fire = o_valid & i_ready;

    assign o_valid = (r_state != ST_EMPTY);
    assign o_data  = r_main;
    assign o_count = r_state;   // state encoding doubles as the entry count
    assign o_ready = w_ready;

    // State and main (output) register; reset discards everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
            r_main  <= BUBBLE_VAL;
        end else begin
            r_state <= w_state_nxt;
            r_main  <= w_main_nxt;
        end
    end

    generate
        if (SKID) begin : g_skid
            logic [WIDTH-1:0] r_skid;
            logic [WIDTH-1:0] w_skid_nxt;
            logic             r_ready;

            assign w_ready = r_ready;

            // Next state: flush wins; FULL drains skid into main on out_fire.
            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                w_skid_nxt  = r_skid;
                if (i_flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE_VAL;
                    w_skid_nxt  = BUBBLE_VAL;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                w_state_nxt = ST_BUSY;
                                w_main_nxt  = i_data;
                            end
                        end
                        ST_BUSY: begin
                            if (w_in_fire && w_out_fire) begin
                                w_main_nxt = i_data;
                            end else if (w_in_fire) begin
                                w_state_nxt = ST_FULL;
                                w_skid_nxt  = i_data;
                            end else if (w_out_fire) begin
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                        ST_FULL: begin
                            // o_ready is low here, so no in_fire can arrive.
                            if (w_out_fire) begin
                                w_state_nxt = ST_BUSY;
                                w_main_nxt  = r_skid;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_EMPTY;
                        end
                    endcase
                end
            end

            // Skid register and registered ready (low only when about to be FULL).
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_skid  <= BUBBLE_VAL;
                    r_ready <= 1'b0;
                end else begin
                    r_skid  <= w_skid_nxt;
                    r_ready <= (w_state_nxt != ST_FULL);
                end
            end
        end else begin : g_noskid
            assign w_ready = !o_valid | i_ready;

            // Next state: single entry, pass-through on simultaneous in/out.
            always_comb begin
                w_state_nxt = r_state;
                w_main_nxt  = r_main;
                if (i_flush) begin
                    w_state_nxt = ST_EMPTY;
                    w_main_nxt  = BUBBLE_VAL;
                end else begin
                    case (r_state)
                        ST_EMPTY: begin
                            if (w_in_fire) begin
                                w_state_nxt = ST_BUSY;
                                w_main_nxt  = i_data;
                            end
                        end
                        ST_BUSY: begin
                            if (w_in_fire) begin
                                w_main_nxt = i_data;
                            end else if (w_out_fire) begin
                                w_state_nxt = ST_EMPTY;
                            end
                        end
                        default: begin
                            w_state_nxt = ST_EMPTY;
                        end
                    endcase
                end
            end
        end
    endgenerate

endmodule
